// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Shared iterative binary-to-BCD converter for two requesters. When idle,
//   the engine grants one request, captures that requester's 8-bit value and
//   runs eight shift-and-add-3 (double-dabble) steps. It then publishes the
//   hundreds/tens/units digits together with a one-cycle done/ack pulse.
//
//   Optional build macro: BCD_ROUND_ROBIN_EN
//     defined   -> a request tie goes to the requester not granted last
//     undefined -> fixed priority, req0 wins ties
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   req0/req1 in   conversion request levels (sampled only while idle)
//   din0/din1 in   8-bit binary values (sampled only at grant)
//   ack0/ack1 out  one-cycle pulse, result valid for that requester
//   busy      out  high whenever the engine is not idle
//   done      out  one-cycle completion pulse, coincident with ack0/ack1
//   grant_id  out  requester owning the current/last conversion
//   hunds     out  hundreds digit (0-2)
//   tens      out  tens digit (0-9)
//   units     out  units digit (0-9)
module bcd_conv_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] din0,
  input  logic       req1,
  input  logic [7:0] din1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       done,
  output logic       grant_id,
  output logic [1:0] hunds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [17:0] sr;       // [17:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary
  logic [2:0]  step;
  logic        gnt;
  logic [17:0] adj;
  logic [17:0] shifted;

`ifdef BCD_ROUND_ROBIN_EN
  logic ptr;  // requester favoured on the next tie

  always_comb begin
    if (req0 && req1) gnt = ptr;
    else              gnt = ~req0;
  end
`else
  always_comb begin
    gnt = ~req0;
  end
`endif

  // Add-3 correction of the tens and units nibbles; hundreds is never corrected.
  always_comb begin
    adj = sr;
    if (sr[11:8] >= 4'd5)  adj[11:8]  = sr[11:8] + 4'd3;
    if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
  end

  // Bit 17 is always clear before any shift (the partial value is at most 127),
  // so rotating it into bit 0 is identical to a plain left shift.
  assign shifted = {adj[16:0], adj[17]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      step     <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      grant_id <= 1'b0;
      hunds    <= '0;
      tens     <= '0;
      units    <= '0;
`ifdef BCD_ROUND_ROBIN_EN
      ptr      <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sr       <= {10'd0, (gnt ? din1 : din0)};
            grant_id <= gnt;
            step     <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
`ifdef BCD_ROUND_ROBIN_EN
            ptr      <= ~gnt;
`endif
          end
        end
        SHIFT: begin
          sr   <= shifted;
          step <= step + 3'd1;
          if (step == 3'd7) begin
            hunds <= shifted[17:16];
            tens  <= shifted[15:12];
            units <= shifted[11:8];
            done  <= 1'b1;
            ack0  <= ~grant_id;
            ack1  <= grant_id;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
